// File: rtl/sme_rf_ctrl_if.sv
// SME share regfile write-port bundle: core writeback, mask refresh,
// zeroise control and the regfile write port itself.
package sme_pkg;
  localparam int XLEN = 32;
endpackage

interface sme_rf_ctrl_if;
  import sme_pkg::*;

  logic            wb_valid;
  logic            wb_ready;
  logic [3:0]      wb_addr;
  logic [XLEN-1:0] wb_wdata;

  logic            rf_valid;
  logic            rf_ready;
  logic [3:0]      rf_addr;
  logic [XLEN-1:0] rf_wdata;

  logic            zero_req;
  logic            zero_busy;
  logic            zero_done;

  logic            rd_wen;
  logic [3:0]      rd_addr;
  logic [XLEN-1:0] rd_wdata;

  modport master (
    output wb_valid, wb_addr, wb_wdata,
    output rf_valid, rf_addr, rf_wdata,
    output zero_req,
    input  wb_ready, rf_ready,
    input  zero_busy, zero_done,
    input  rd_wen, rd_addr, rd_wdata
  );

  modport slave (
    input  wb_valid, wb_addr, wb_wdata,
    input  rf_valid, rf_addr, rf_wdata,
    input  zero_req,
    output wb_ready, rf_ready,
    output zero_busy, zero_done,
    output rd_wen, rd_addr, rd_wdata
  );
endinterface

// File: rtl/sme_rf_ctrl.sv
// Write-port arbiter and zeroise sequencer for the 16-entry SME share
// register file.
module sme_rf_ctrl
  import sme_pkg::*;
#(
  parameter int STARVE_MAX    = 8,
  parameter bit ZERO_ON_RESET = 1'b1
) (
  input  logic         g_clk,
  input  logic         g_resetn,
  output logic         g_clk_req,
  sme_rf_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ZERO,
    S_DONE
  } state_t;

  localparam state_t     RST_ST = ZERO_ON_RESET ? S_ZERO : S_IDLE;
  localparam logic [3:0] SMAX   = 4'(STARVE_MAX);

  state_t          state, state_nx;
  logic [3:0]      zcnt, zcnt_nx;
  logic [3:0]      starve, starve_nx;
  logic            gnt_wb, gnt_rf, force_rf;
  logic            wen, busy, done;
  logic [3:0]      waddr;
  logic [XLEN-1:0] wdata;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state  <= RST_ST;
      zcnt   <= '0;
      starve <= '0;
    end else begin
      state  <= state_nx;
      zcnt   <= zcnt_nx;
      starve <= starve_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    zcnt_nx   = zcnt;
    starve_nx = starve;
    gnt_wb    = 1'b0;
    gnt_rf    = 1'b0;
    force_rf  = 1'b0;
    wen       = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    waddr     = '0;
    wdata     = '0;
    unique case (1'b1)
      (state == S_IDLE): begin
        force_rf = bus.rf_valid && (starve >= SMAX);
        gnt_rf   = bus.rf_valid && (force_rf || !bus.wb_valid);
        gnt_wb   = bus.wb_valid && !gnt_rf;
        if (gnt_wb) begin
          wen   = 1'b1;
          waddr = bus.wb_addr;
          wdata = bus.wb_wdata;
        end else if (gnt_rf) begin
          wen   = 1'b1;
          waddr = bus.rf_addr;
          wdata = bus.rf_wdata;
        end
        // Starvation only counts while refresh is waiting and losing.
        if (!bus.rf_valid || gnt_rf)
          starve_nx = '0;
        else if (starve != 4'hF)
          starve_nx = starve + 4'd1;
        if (bus.zero_req)
          state_nx = S_ZERO;
      end
      (state == S_ZERO): begin
        wen     = 1'b1;
        waddr   = zcnt;
        busy    = 1'b1;
        zcnt_nx = zcnt + 4'd1;
        if (zcnt == 4'hF)
          state_nx = S_DONE;
      end
      (state == S_DONE): begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Everything toward requesters and regfile is forced quiet in reset.
  assign bus.wb_ready  = g_resetn & gnt_wb;
  assign bus.rf_ready  = g_resetn & gnt_rf;
  assign bus.zero_busy = g_resetn & busy;
  assign bus.zero_done = g_resetn & done;
  assign bus.rd_wen    = g_resetn & wen;
  assign bus.rd_addr   = g_resetn ? waddr : '0;
  assign bus.rd_wdata  = g_resetn ? wdata : '0;

  assign g_clk_req = bus.wb_valid | bus.rf_valid | bus.zero_req |
                     (state != S_IDLE);

endmodule
